// File: rtl/clkdiv_bank_pkg.sv
// Shared types and default parameters for the clkdiv_bank clock-divider bank.
package clkdiv_bank_pkg;

  localparam int DEF_NUM_CLK     = 4;
  localparam int DEF_DIV_W       = 8;
  localparam int DEF_LOCK_CYCLES = 16;
  localparam int LOCK_CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: phase delay, D-cycle counter and registered edge outputs.
module clkdiv_chan
  import clkdiv_bank_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] phase,
  output logic             outclk,
  output logic             outclk_en
);

  logic [DIV_W-1:0] dly_q;
  logic [DIV_W-1:0] pos_q;
  logic [DIV_W-1:0] phase_c;
  logic [DIV_W-1:0] high_len;
  logic [DIV_W-1:0] eff_dly;
  logic [DIV_W-1:0] eff_pos;
  logic [DIV_W-1:0] pos_nxt;

  // start marks the edge that produces the first SETTLE cycle, so the
  // captured phase is used directly instead of the stale delay register.
  always_comb begin
    if (div == '0)
      phase_c = '0;
    else if (phase >= div)
      phase_c = div - DIV_W'(1);
    else
      phase_c = phase;
    high_len = (div >> 1) + DIV_W'(div[0]);
    eff_dly  = start ? phase_c : dly_q;
    eff_pos  = start ? '0 : pos_q;
    pos_nxt  = (eff_pos == div - DIV_W'(1)) ? '0 : eff_pos + DIV_W'(1);
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q     <= '0;
      pos_q     <= '0;
      outclk    <= 1'b0;
      outclk_en <= 1'b0;
    end else if (!run || div == '0) begin
      dly_q     <= '0;
      pos_q     <= '0;
      outclk    <= 1'b0;
      outclk_en <= 1'b0;
    end else if (eff_dly != '0) begin
      dly_q     <= eff_dly - DIV_W'(1);
      pos_q     <= '0;
      outclk    <= 1'b0;
      outclk_en <= 1'b0;
    end else begin
      dly_q     <= '0;
      pos_q     <= pos_nxt;
      outclk    <= (eff_pos < high_len);
      outclk_en <= (eff_pos == '0);
    end
  end

endmodule

// File: rtl/clkdiv_bank.sv
// Bank of NUM_CLK phase-aligned clock dividers with a lock controller.
// Optional relock_cnt output is enabled by defining CLKDIV_BANK_RELOCK_CNT_EN.
module clkdiv_bank
  import clkdiv_bank_pkg::*;
#(
  parameter int NUM_CLK     = DEF_NUM_CLK,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                     refclk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [NUM_CLK*DIV_W-1:0] div_ratio,
  input  logic [NUM_CLK*DIV_W-1:0] phase,
  output logic [NUM_CLK-1:0]       outclk,
  output logic [NUM_CLK-1:0]       outclk_en,
  output logic                     locked
`ifdef CLKDIV_BANK_RELOCK_CNT_EN
  ,
  output logic [7:0]               relock_cnt
`endif
);

  localparam logic [LOCK_CNT_W-1:0] SETTLE_LAST = LOCK_CNT_W'(LOCK_CYCLES - 1);

  state_e                   state_q;
  state_e                   state_d;
  logic                     ready_q;
  logic                     cfg_hs;
  logic                     run_next;
  logic                     start;
  logic [LOCK_CNT_W-1:0]    settle_cnt;
  logic [NUM_CLK*DIV_W-1:0] div_q;
  logic [NUM_CLK*DIV_W-1:0] phase_q;

  // ready_q keeps cfg_ready low during reset and until the first edge after it.
  assign cfg_ready = ready_q && (state_q != ST_ALIGN);
  assign cfg_hs    = cfg_valid && cfg_ready;
  assign locked    = (state_q == ST_LOCKED);
  assign run_next  = (state_d == ST_SETTLE) || (state_d == ST_LOCKED);
  assign start     = (state_q == ST_ALIGN);

  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (cfg_hs) state_d = ST_ALIGN;
      ST_ALIGN:  state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (cfg_hs)
          state_d = ST_ALIGN;
        else if (settle_cnt == SETTLE_LAST)
          state_d = ST_LOCKED;
      end
      ST_LOCKED: if (cfg_hs) state_d = ST_ALIGN;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      settle_cnt <= '0;
      div_q      <= '0;
      phase_q    <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      if (state_q == ST_SETTLE)
        settle_cnt <= settle_cnt + LOCK_CNT_W'(1);
      else
        settle_cnt <= '0;
      if (cfg_hs) begin
        div_q   <= div_ratio;
        phase_q <= phase;
      end
    end
  end

`ifdef CLKDIV_BANK_RELOCK_CNT_EN
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)
      relock_cnt <= '0;
    else if (cfg_hs && state_q == ST_LOCKED && relock_cnt != 8'hFF)
      relock_cnt <= relock_cnt + 8'd1;
  end
`else
  // Relock counter is not part of this build.
`endif

  for (genvar i = 0; i < NUM_CLK; i++) begin : g_chan
    clkdiv_chan #(
      .DIV_W (DIV_W)
    ) u_chan (
      .clk       (refclk),
      .rst_n     (rst_n),
      .run       (run_next),
      .start     (start),
      .div       (div_q[i*DIV_W +: DIV_W]),
      .phase     (phase_q[i*DIV_W +: DIV_W]),
      .outclk    (outclk[i]),
      .outclk_en (outclk_en[i])
    );
  end

endmodule
